hazard_forwarding_unit: RTL and testbench

// Hazard detection and forwarding control for the 5-stage RISC-V pipeline. Tracks the

---
 rtl/hazard_forwarding_unit_if.sv | 46 ++++
 rtl/hazard_forwarding_unit.sv | 108 ++++++++++
 tb/tb_hazard_forwarding_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/hazard_forwarding_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_forwarding_unit_if
// Bundles the decode-stage request and the hazard/forwarding control response
// exchanged between the pipeline datapath and the hazard forwarding unit.
//   ID_rs1, ID_rs2           source registers of the instruction in ID
//   ID_rs1_used, ID_rs2_used ID instruction actually reads rs1 / rs2
//   ID_rd, ID_RF_Enable      destination register and its write enable
//   ID_Load_Instr            ID instruction is a load
//   flush                    taken branch/jump; kill the ID instruction
//   CU_mux_sel               1 = control-unit mux emits an all-zero NOP
//   PC_LE, IFID_LE           PC and IF/ID register load enables
//   fwd_A_sel, fwd_B_sel     operand mux selects: 00 RF, 01 EX, 10 MEM, 11 WB
//   stall_count              load-use stall cycles since reset (saturating)
// Modports: master = pipeline side, slave = hazard unit side.
// ---------------------------------------------------------------------------
interface hazard_forwarding_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] ID_rs1;
  logic [REG_ADDR_W-1:0] ID_rs2;
  logic                  ID_rs1_used;
  logic                  ID_rs2_used;
  logic [REG_ADDR_W-1:0] ID_rd;
  logic                  ID_RF_Enable;
  logic                  ID_Load_Instr;
  logic                  flush;
  logic                  CU_mux_sel;
  logic                  PC_LE;
  logic                  IFID_LE;
  logic [1:0]            fwd_A_sel;
  logic [1:0]            fwd_B_sel;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used,
    output ID_rd, ID_RF_Enable, ID_Load_Instr, flush,
    input  CU_mux_sel, PC_LE, IFID_LE, fwd_A_sel, fwd_B_sel, stall_count
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used,
    input  ID_rd, ID_RF_Enable, ID_Load_Instr, flush,
    output CU_mux_sel, PC_LE, IFID_LE, fwd_A_sel, fwd_B_sel, stall_count
  );
endinterface

// File: rtl/hazard_forwarding_unit.sv
// ---------------------------------------------------------------------------
// hazard_forwarding_unit
// Hazard detection and operand-forwarding control for a 5-stage RISC-V
// pipeline. A 3-slot shadow pipeline (EX, MEM, WB) records {rd, rf_en, load}
// of each in-flight instruction. All control outputs are combinational from
// the slot state and the ID-stage inputs; the slots advance once per clock.
// Ports:
//   clk    pipeline clock, state updates on the rising edge
//   reset  asynchronous, active-high reset (clears slots and stall counter)
//   bus    hazard_forwarding_unit_if.slave: ID request in, control out
// ---------------------------------------------------------------------------
module hazard_forwarding_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  hazard_forwarding_unit_if.slave  bus
);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t rd;
    logic      rf_en;
    logic      load;
  } slot_t;

  localparam slot_t BUBBLE = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  slot_t            ex_q, mem_q, wb_q;
  slot_t            ex_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             stall;
  fwd_sel_e         fwd_a, fwd_b;

  // x0 is hardwired to zero, so a write to it never produces a hazard.
  function automatic logic slot_match(slot_t s, reg_addr_t rs);
    return s.rf_en && (s.rd != '0) && (s.rd == rs);
  endfunction

  // A load in EX has no data yet, so it is skipped here; the stall logic
  // holds the consumer until the load reaches MEM.
  function automatic fwd_sel_e fwd_select(reg_addr_t rs, logic used,
                                          slot_t ex, slot_t mem, slot_t wb);
    if (!used)                               return FWD_RF;
    if (slot_match(ex, rs) && !ex.load)      return FWD_EX;
    if (slot_match(mem, rs))                 return FWD_MEM;
    if (slot_match(wb, rs))                  return FWD_WB;
    return FWD_RF;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default at the top so
  // no path leaves it unassigned (which would infer a latch).
  always_comb begin
    stall         = 1'b0;
    ex_d          = BUBBLE;
    stall_count_d = stall_count_q;

    // A flush kills the ID instruction anyway, so it overrides a load-use stall.
    stall = !bus.flush && ex_q.load &&
            ((bus.ID_rs1_used && slot_match(ex_q, bus.ID_rs1)) ||
             (bus.ID_rs2_used && slot_match(ex_q, bus.ID_rs2)));

    if (!(stall || bus.flush)) begin
      ex_d = '{rd: bus.ID_rd, rf_en: bus.ID_RF_Enable, load: bus.ID_Load_Instr};
    end

    // Saturate rather than wrap.
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end

    fwd_a = fwd_select(bus.ID_rs1, bus.ID_rs1_used, ex_q, mem_q, wb_q);
    fwd_b = fwd_select(bus.ID_rs2, bus.ID_rs2_used, ex_q, mem_q, wb_q);
  end

  assign bus.CU_mux_sel  = stall | bus.flush;
  assign bus.PC_LE       = ~stall;
  assign bus.IFID_LE     = ~stall;
  assign bus.fwd_A_sel   = fwd_a;
  assign bus.fwd_B_sel   = fwd_b;
  assign bus.stall_count = stall_count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values (WB<=MEM<=EX shifts correctly).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q          <= BUBBLE;
      mem_q         <= BUBBLE;
      wb_q          <= BUBBLE;
      stall_count_q <= '0;
    end else begin
      wb_q          <= mem_q;
      mem_q         <= ex_q;
      ex_q          <= ex_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_forwarding_unit
// Directed bench for hazard_forwarding_unit. A 32-bit-counter instance and a
// 2-bit-counter instance see identical stimulus; the second one exposes the
// counter saturation. Expected responses are hand-derived for each step.
// ---------------------------------------------------------------------------
module tb_hazard_forwarding_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_forwarding_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) bus_m ();
  hazard_forwarding_unit_if #(.REG_ADDR_W(5), .CNT_W(2))  bus_s ();

  assign bus_s.ID_rs1        = bus_m.ID_rs1;
  assign bus_s.ID_rs2        = bus_m.ID_rs2;
  assign bus_s.ID_rs1_used   = bus_m.ID_rs1_used;
  assign bus_s.ID_rs2_used   = bus_m.ID_rs2_used;
  assign bus_s.ID_rd         = bus_m.ID_rd;
  assign bus_s.ID_RF_Enable  = bus_m.ID_RF_Enable;
  assign bus_s.ID_Load_Instr = bus_m.ID_Load_Instr;
  assign bus_s.flush         = bus_m.flush;

  hazard_forwarding_unit #(.REG_ADDR_W(5), .CNT_W(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_m)
  );

  hazard_forwarding_unit #(.REG_ADDR_W(5), .CNT_W(2)) u_dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  typedef struct {
    string       tag;
    logic        cu;
    logic        le;
    logic [1:0]  fa;
    logic [1:0]  fb;
    int unsigned cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One directed step: optionally wait for the falling edge, drive the ID
  // inputs, queue the expected response, then compare 1 time unit later.
  task automatic apply(string tag, bit adv, logic rst,
                       logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                       logic [4:0] rd, logic rf, logic ld, logic fl,
                       logic cu, logic le, logic [1:0] fa, logic [1:0] fb,
                       int unsigned cnt);
    exp_t e;
    if (adv) @(negedge clk);
    reset                = rst;
    bus_m.ID_rs1         = rs1;
    bus_m.ID_rs1_used    = u1;
    bus_m.ID_rs2         = rs2;
    bus_m.ID_rs2_used    = u2;
    bus_m.ID_rd          = rd;
    bus_m.ID_RF_Enable   = rf;
    bus_m.ID_Load_Instr  = ld;
    bus_m.flush          = fl;
    e.tag = tag; e.cu = cu; e.le = le; e.fa = fa; e.fb = fb; e.cnt = cnt;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check({e.tag, ".cu"},   32'(bus_m.CU_mux_sel), 32'(e.cu));
    check({e.tag, ".pc"},   32'(bus_m.PC_LE),      32'(e.le));
    check({e.tag, ".ifid"}, 32'(bus_m.IFID_LE),    32'(e.le));
    check({e.tag, ".fa"},   32'(bus_m.fwd_A_sel),  32'(e.fa));
    check({e.tag, ".fb"},   32'(bus_m.fwd_B_sel),  32'(e.fb));
    check({e.tag, ".cnt"},  bus_m.stall_count,     e.cnt);
    check({e.tag, ".cnt2"}, 32'(bus_s.stall_count), (e.cnt > 3) ? 32'd3 : e.cnt);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus_m.ID_rs1 = '0; bus_m.ID_rs1_used = 1'b0; bus_m.ID_rs2 = '0; bus_m.ID_rs2_used = 1'b0;
    bus_m.ID_rd = '0;  bus_m.ID_RF_Enable = 1'b0; bus_m.ID_Load_Instr = 1'b0; bus_m.flush = 1'b0;

    //     tag            adv rst rs1 u1 rs2 u2 rd  rf ld fl  cu le fa     fb     cnt
    apply("rst_hold",     1, 1,  0, 0,  0, 0,  0, 0, 0, 0,  0, 1, 2'b00, 2'b00, 0);
    apply("idle",         1, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 1, 2'b00, 2'b00, 0);
    // ADD x5 then consumers at distance 1, 2, 3, 4
    apply("add_x5",       1, 0,  1, 1,  2, 1,  5, 1, 0, 0,  0, 1, 2'b00, 2'b00, 0);
    apply("fwdA_ex",      1, 0,  5, 1,  6, 1,  6, 1, 0, 0,  0, 1, 2'b01, 2'b00, 0);
    apply("fwdB_mem",     1, 0,  1, 1,  5, 1,  0, 0, 0, 0,  0, 1, 2'b00, 2'b10, 0);
    apply("fwdB_wb",      1, 0,  1, 1,  5, 1,  0, 0, 0, 0,  0, 1, 2'b00, 2'b11, 0);
    apply("fwdB_rf",      1, 0,  6, 1,  5, 1,  0, 0, 0, 0,  0, 1, 2'b11, 2'b00, 0);
    // LW x7 then dependent ADD: one stall, then forward from MEM
    apply("lw_x7",        1, 0,  1, 1,  0, 0,  7, 1, 1, 0,  0, 1, 2'b00, 2'b00, 0);
    apply("lu_stall",     1, 0,  2, 1,  7, 1,  8, 1, 0, 0,  1, 0, 2'b00, 2'b00, 0);
    apply("lu_fwd_mem",   1, 0,  2, 1,  7, 1,  8, 1, 0, 0,  0, 1, 2'b00, 2'b10, 1);
    // EX / WB forwarding together, then x0 destinations never forward or stall
    apply("ex_and_wb",    1, 0,  8, 1,  7, 1,  0, 1, 0, 0,  0, 1, 2'b01, 2'b11, 1);
    apply("x0_add",       1, 0,  0, 1,  0, 1,  0, 1, 1, 0,  0, 1, 2'b00, 2'b00, 1);
    apply("x0_load",      1, 0,  0, 1,  0, 1,  9, 1, 0, 0,  0, 1, 2'b00, 2'b00, 1);
    apply("rs_unused",    1, 0,  9, 0,  3, 0,  9, 1, 0, 0,  0, 1, 2'b00, 2'b00, 1);
    // x9 in both EX and MEM: EX wins; then MEM over WB
    apply("ex_priority",  1, 0,  9, 1,  9, 1,  0, 0, 0, 0,  0, 1, 2'b01, 2'b01, 1);
    apply("mem_over_wb",  1, 0,  9, 1,  0, 0,  3, 1, 1, 0,  0, 1, 2'b10, 2'b00, 1);
    // LW x3 with a dependent use that is flushed: no stall, bubble into EX
    apply("flush_wins",   1, 0,  3, 1,  0, 0,  4, 1, 0, 1,  1, 1, 2'b00, 2'b00, 1);
    apply("flush_bubble", 1, 0,  3, 1,  4, 1,  0, 0, 0, 0,  0, 1, 2'b10, 2'b00, 1);
    // lw x10,0(x10) repeated: alternating stall / forward cycles
    apply("lw_x10",       1, 0,  1, 1,  0, 0, 10, 1, 1, 0,  0, 1, 2'b00, 2'b00, 1);
    for (int k = 0; k < 4; k++) begin
      apply("ld_stall",   1, 0, 10, 1,  0, 0, 10, 1, 1, 0,  1, 0,
            (k == 0) ? 2'b00 : 2'b11, 2'b00, 1 + k);
      apply("ld_fwd",     1, 0, 10, 1,  0, 0, 10, 1, 1, 0,  0, 1, 2'b10, 2'b00, 2 + k);
    end
    // Reset asserted in the middle of a stall cycle
    apply("pre_rst",      1, 0, 10, 1,  0, 0, 10, 1, 1, 0,  1, 0, 2'b11, 2'b00, 5);
    apply("rst_mid",      0, 1, 10, 1,  0, 0, 10, 1, 1, 0,  0, 1, 2'b00, 2'b00, 0);
    apply("post_rst",     1, 0, 10, 1, 10, 1,  0, 0, 0, 0,  0, 1, 2'b00, 2'b00, 0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
